// File: rtl/mfp_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : mfp_input_debouncer
// Brief    : Two-flop synchronizer plus per-channel debounce for the slide
//            switches and pushbuttons, with optional pushbutton press pulses
//            (enabled by defining MFP_DEBOUNCE_PRESS_PULSE_EN).
// Revision : 1.0 - initial release
// ============================================================================
module mfp_input_debouncer #(
    parameter int N_SW            = 16,
    parameter int N_PB            = 5,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic            SI_ClkIn,
    input  logic            SI_Reset,
    input  logic [N_SW-1:0] RAW_SW,
    input  logic [N_PB-1:0] RAW_PB,
    output logic [N_SW-1:0] IO_Switch,
    output logic [N_PB-1:0] IO_PB,
    output logic [N_PB-1:0] PB_PRESS
);

    localparam int c_N_CH  = N_SW + N_PB;
    localparam int c_CNT_W = ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 : $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

    logic [c_N_CH-1:0] w_raw;
    logic [c_N_CH-1:0] r_s1;
    logic [c_N_CH-1:0] r_s2;
    logic [c_N_CH-1:0] w_db;

    assign w_raw = {RAW_PB, RAW_SW};

    // Plain back-to-back flops: nothing may sit between the two stages.
    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= w_raw;
            r_s2 <= r_s1;
        end
    end

    generate
        for (genvar i = 0; i < c_N_CH; i++) begin : g_ch
            logic [c_CNT_W-1:0] r_cnt;
            logic               r_db;

            // Any cycle where the synchronized level agrees with the accepted
            // level restarts the window, so short bounces never accumulate.
            always_ff @(posedge SI_ClkIn) begin
                if (SI_Reset) begin
                    r_cnt <= '0;
                    r_db  <= 1'b0;
                end else if (r_s2[i] == r_db) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_CNT_MAX) begin
                    r_db  <= r_s2[i];
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_CNT_ONE;
                end
            end

            assign w_db[i] = r_db;
        end
    endgenerate

    assign IO_Switch = w_db[N_SW-1:0];
    assign IO_PB     = w_db[c_N_CH-1:N_SW];

`ifdef MFP_DEBOUNCE_PRESS_PULSE_EN
    logic [N_PB-1:0] r_db_d;

    always_ff @(posedge SI_ClkIn) begin
        if (SI_Reset) begin
            r_db_d <= '0;
        end else begin
            r_db_d <= w_db[c_N_CH-1:N_SW];
        end
    end

    assign PB_PRESS = w_db[c_N_CH-1:N_SW] & ~r_db_d;
`else
    assign PB_PRESS = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mfp_input_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mfp_input_debouncer
// Brief    : Randomized and directed bench for mfp_input_debouncer against a
//            window-based reference model (DEBOUNCE_CYCLES = 4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mfp_input_debouncer;

    localparam int c_N_SW = 16;
    localparam int c_N_PB = 5;
    localparam int c_DB   = 4;
    localparam int c_N_CH = c_N_SW + c_N_PB;
`ifdef MFP_DEBOUNCE_PRESS_PULSE_EN
    localparam bit c_PULSE = 1'b1;
`else
    localparam bit c_PULSE = 1'b0;
`endif

    logic              SI_ClkIn = 1'b0;
    logic              SI_Reset = 1'b1;
    logic [c_N_SW-1:0] RAW_SW   = '1;
    logic [c_N_PB-1:0] RAW_PB   = '0;
    logic [c_N_SW-1:0] IO_Switch;
    logic [c_N_PB-1:0] IO_PB;
    logic [c_N_PB-1:0] PB_PRESS;

    int checks = 0;
    int errors = 0;

    mfp_input_debouncer #(
        .N_SW           (c_N_SW),
        .N_PB           (c_N_PB),
        .DEBOUNCE_CYCLES(c_DB)
    ) dut (
        .SI_ClkIn (SI_ClkIn),
        .SI_Reset (SI_Reset),
        .RAW_SW   (RAW_SW),
        .RAW_PB   (RAW_PB),
        .IO_Switch(IO_Switch),
        .IO_PB    (IO_PB),
        .PB_PRESS (PB_PRESS)
    );

    always #5 SI_ClkIn = ~SI_ClkIn;

    // Reference model: a channel flips once its last c_DB synchronized samples
    // all disagree with the accepted level; reset empties the sample history.
    logic [c_N_CH-1:0] m_s1 = '0;
    logic [c_N_CH-1:0] m_s2 = '0;
    logic [c_N_CH-1:0] m_db = '0;
    logic [c_N_CH-1:0] m_db_d = '0;
    logic [c_N_CH-1:0] hist[$];

    initial begin
        forever begin
            logic [c_N_CH-1:0] pre;
            logic [c_N_CH-1:0] nxt;
            logic [c_N_PB-1:0] exp_press;
            @(posedge SI_ClkIn);
            if (SI_Reset) begin
                m_s1 = '0; m_s2 = '0; m_db = '0; m_db_d = '0;
                hist.delete();
            end else begin
                pre  = m_s2;
                m_s2 = m_s1;
                m_s1 = {RAW_PB, RAW_SW};
                hist.push_back(pre);
                if (hist.size() > c_DB) void'(hist.pop_front());
                nxt = m_db;
                if (hist.size() == c_DB) begin
                    for (int b = 0; b < c_N_CH; b++) begin
                        bit all_diff;
                        all_diff = 1'b1;
                        for (int j = 0; j < c_DB; j++)
                            if (hist[j][b] == m_db[b]) all_diff = 1'b0;
                        if (all_diff) nxt[b] = ~m_db[b];
                    end
                end
                m_db_d = m_db;
                m_db   = nxt;
            end
            exp_press = c_PULSE ? (m_db[c_N_CH-1:c_N_SW] & ~m_db_d[c_N_CH-1:c_N_SW]) : '0;
            #1;
            checks++;
            if (IO_Switch !== m_db[c_N_SW-1:0]) begin
                errors++;
                $display("FAIL model_sw t=%0t actual=%h expected=%h", $time, IO_Switch, m_db[c_N_SW-1:0]);
            end
            checks++;
            if (IO_PB !== m_db[c_N_CH-1:c_N_SW]) begin
                errors++;
                $display("FAIL model_pb t=%0t actual=%b expected=%b", $time, IO_PB, m_db[c_N_CH-1:c_N_SW]);
            end
            checks++;
            if (PB_PRESS !== exp_press) begin
                errors++;
                $display("FAIL model_press t=%0t actual=%b expected=%b", $time, PB_PRESS, exp_press);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge SI_ClkIn);
    endtask

    initial begin
        // Reset with all switches high.
        wait_n(5);
        chk("rst_sw", 32'(IO_Switch), 32'h0);
        chk("rst_pb", 32'(IO_PB), 32'h0);
        chk("rst_press", 32'(PB_PRESS), 32'h0);
        SI_Reset = 1'b0;
        wait_n(5);
        chk("rst_sw_edge5", 32'(IO_Switch), 32'h0);
        wait_n(1);
        chk("rst_sw_edge6", 32'(IO_Switch), 32'hFFFF);

        RAW_SW = '0;
        wait_n(8);
        chk("sw_clear", 32'(IO_Switch), 32'h0);

        // Clean press of button 0.
        RAW_PB = 5'b00001;
        wait_n(5);
        chk("press_early", 32'(IO_PB), 32'h0);
        wait_n(1);
        chk("press_pb", 32'(IO_PB), 32'h1);
        chk("press_pulse", 32'(PB_PRESS), c_PULSE ? 32'h1 : 32'h0);
        wait_n(1);
        chk("press_pulse_end", 32'(PB_PRESS), 32'h0);

        // 3-cycle glitch rejected, 4-cycle pulse accepted.
        RAW_SW[3] = 1'b1;
        wait_n(3);
        RAW_SW[3] = 1'b0;
        wait_n(10);
        chk("glitch3", 32'(IO_Switch), 32'h0);
        RAW_SW[3] = 1'b1;
        wait_n(4);
        RAW_SW[3] = 1'b0;
        wait_n(2);
        chk("glitch4", 32'(IO_Switch), 32'h8);
        wait_n(10);
        chk("glitch4_fall", 32'(IO_Switch), 32'h0);

        // Bounce on button 2, then hold.
        for (int t = 0; t < 10; t++) begin
            RAW_PB[2] = ~RAW_PB[2];
            wait_n(2);
        end
        RAW_PB[2] = 1'b1;
        wait_n(5);
        chk("bounce_early", 32'(IO_PB), 32'h1);
        wait_n(1);
        chk("bounce_rise", 32'(IO_PB), 32'h5);
        chk("bounce_pulse", 32'(PB_PRESS), c_PULSE ? 32'h4 : 32'h0);

        // Simultaneous release of buttons 0 and 4.
        RAW_PB[4] = 1'b1;
        wait_n(8);
        RAW_PB = 5'b00100;
        wait_n(5);
        chk("release_early", 32'(IO_PB), 32'h15);
        wait_n(1);
        chk("release_fall", 32'(IO_PB), 32'h4);
        chk("release_nopulse", 32'(PB_PRESS), 32'h0);

        // All switches at once.
        RAW_SW = '1;
        wait_n(5);
        chk("allsw_early", 32'(IO_Switch), 32'h0);
        wait_n(1);
        chk("allsw_rise", 32'(IO_Switch), 32'hFFFF);

        // Reset mid-count with buttons held through it.
        RAW_PB[1] = 1'b1;
        wait_n(2);
        SI_Reset = 1'b1;
        wait_n(2);
        chk("midrst_pb", 32'(IO_PB), 32'h0);
        SI_Reset = 1'b0;
        wait_n(5);
        chk("midrst_early", 32'(IO_PB), 32'h0);
        wait_n(1);
        chk("midrst_rise", 32'(IO_PB), 32'h6);
        chk("midrst_pulse", 32'(PB_PRESS), c_PULSE ? 32'h6 : 32'h0);

        // Randomized phase: sparse bit flips and occasional short resets.
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < c_N_SW; b++)
                if ($urandom_range(0, 9) == 0) RAW_SW[b] = ~RAW_SW[b];
            for (int b = 0; b < c_N_PB; b++)
                if ($urandom_range(0, 7) == 0) RAW_PB[b] = ~RAW_PB[b];
            SI_Reset = ($urandom_range(0, 199) == 0);
            wait_n(1);
        end
        SI_Reset = 1'b0;
        wait_n(10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
